mult_issue_ctrl: RTL and testbench
==================================

# mult_issue_ctrl

Operand-issue and result-capture stage wrapped around the 32-bit shift-add multiplier. It accepts operand pairs over a valid/ready handshake and holds them stable on the multiplier inputs. It parks and restarts the multiplier through its synchronous active-high reset, waits a fixed worst-case latency, then captures the 64-bit product into a small result FIFO drained by a downstream valid/ready consumer. Only one multiplication is in flight at a time.

## Interface
- `WIDTH`, default 32: operand width; the product is 2*WIDTH.
- `LAT`, default 100: cycles spent in RUN. Elaboration error if `LAT < 3*WIDTH+1`, the multiplier's worst case of 1 + 3 cycles per bit.
- `DEPTH`, default 2: result FIFO entries, power of two, at least 2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: block can accept an operand pair.
- `in_mcand` in WIDTH: multiplicand.
- `in_mlier` in WIDTH: multiplier.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: consumer takes the head.
- `out_product` out 2*WIDTH: FIFO head, unsigned product.
- `mult_mcand` out WIDTH: registered multiplicand to the multiplier.
- `mult_mlier` out WIDTH: registered multiplier operand to the multiplier.
- `mult_rst` out 1: active-high synchronous reset to the multiplier.
- `mult_product` in 2*WIDTH: product from the multiplier.
- `busy` out 1: a job is in flight (state is not IDLE).

## Operation
- FSM states: IDLE, LOAD, RUN, CAPTURE.
- IDLE:
  - `mult_rst=1`.
  - `in_ready = (state==IDLE) && (fifo_count < DEPTH)`, combinational.
  - On `in_valid && in_ready`: latch `in_mcand` into `mult_mcand` and `in_mlier` into `mult_mlier`, then go to LOAD.
- LOAD: one cycle, `mult_rst=1` so the multiplier enters its idle/load state with the new operands present. Then go to RUN with `run_cnt=0`.
- RUN:
  - `mult_rst=0`; `run_cnt` increments each cycle.
  - When `run_cnt==LAT-1`, go to CAPTURE.
  - `run_cnt` is `$clog2(LAT)` bits and never wraps.
- CAPTURE: push `mult_product` into the FIFO at the exiting edge, then go to IDLE. Space is guaranteed because acceptance requires `fifo_count<DEPTH` and only CAPTURE pushes.
- `mult_mcand` and `mult_mlier` hold their values from acceptance until the next acceptance. They never change during LOAD, RUN or CAPTURE.
- FIFO behaviour:
  - Show-ahead: `out_product` = head, `out_valid = (fifo_count != 0)`.
  - Pop on `out_valid && out_ready`.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo DEPTH.
  - `out_product` is don't-care when empty, held at its last value.
- Reset values (`rst_n` low, asynchronous):
  - state=IDLE, `run_cnt=0`, FIFO empty with pointers 0.
  - `out_valid=0`, `busy=0`, `mult_rst=1`, `mult_mcand=0`, `mult_mlier=0`, `in_ready=1`.
  - Handshakes while `rst_n` is low are ignored.
- Reset mid-operation: an in-flight job is dropped, no product is pushed, and FIFO contents are lost.

## Timing
- With acceptance at edge E0:
  - LOAD runs E0..E1.
  - RUN runs E1..E(LAT+1).
  - CAPTURE runs for one cycle.
  - The push lands at E(LAT+2).
- `out_valid` rises after E(LAT+2). With default parameters that is 102 cycles after acceptance when the FIFO was empty.
- `in_ready` re-asserts in the cycle after the push, if the FIFO has space.
- Maximum throughput: one job per LAT+3 cycles.
- `out_valid` only falls after a pop of the last entry. It never depends combinationally on `out_ready`.

## Structure
- Shared package `mult_pkg`:
  - state enum `mult_issue_state_t`.
  - `MULT_WIDTH=32`.
  - function `mult_min_lat(width)` returning `3*width+1`, used by the parameter check.
- Sub-module `mult_result_fifo`, parameterised by DEPTH and data width, synchronous with asynchronous active-low reset. The FSM, counter and operand registers stay in the top.

## Test plan
- Reset, then `3 * 5` with `out_ready=1`: `out_product=64'h0000_0000_0000_000F` with `out_valid` first high 102 cycles after acceptance, and `busy` low afterwards.
- `32'hFFFF_FFFF * 32'hFFFF_FFFF`: `out_product=64'hFFFF_FFFE_0000_0001`. Also run `0 * 32'h1234_5678`: `out_product=0`.
- Back-pressure with `out_ready=0` and three jobs (`2*3`, `4*5`, `6*7`): after two captures, `in_ready` stays 0 with 6 and 20 queued. One pop lets the third job be accepted. Final drain order is 6, 20, 42.
- Operand stability: toggle `in_mcand` and `in_mlier` randomly while `busy=1`. `mult_mcand` and `mult_mlier` must stay constant and the product must match the accepted pair.
- Reset mid-RUN, with `rst_n` low at `run_cnt=40`: outputs immediately take their reset values, and no result appears afterwards. A following job `7*9` returns 63.
- Simultaneous push/pop: with the FIFO holding 1 entry and `out_ready=1` during CAPTURE, the count stays 1, the old head pops, and the new product becomes the head.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier issue/capture stage.
package mult_pkg;

  localparam int MULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_CAPTURE
  } mult_issue_state_t;

  // Worst-case multiplier latency: one load cycle plus three cycles per bit.
  function automatic int mult_min_lat(input int width);
    return 3 * width + 1;
  endfunction

endpackage

// File: rtl/mult_result_fifo.sv
// Show-ahead result FIFO; the head is visible on the data output whenever valid is high.
module mult_result_fifo #(
  parameter int DEPTH = 2,
  parameter int DW    = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          full,
  output logic          valid,
  output logic [DW-1:0] head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [DW-1:0] mem [DEPTH];
  ptr_t          wr_ptr;
  ptr_t          rd_ptr;
  cnt_t          count;
  logic          do_pop;

  assign do_pop = pop && valid;
  assign valid  = (count != '0);
  assign full   = (count == cnt_t'(DEPTH));

  // When empty, keep presenting the entry that was popped last.
  assign head = valid ? mem[rd_ptr] : mem[rd_ptr - ptr_t'(1)];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + ptr_t'(1);
      if (do_pop) rd_ptr <= rd_ptr + ptr_t'(1);
      case ({push, do_pop})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mult_issue_ctrl.sv
// Issues one operand pair at a time to the multiplier, waits its worst-case latency,
// and captures the product into a small result FIFO.
module mult_issue_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int LAT   = 100,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_mcand,
  input  logic [WIDTH-1:0]   in_mlier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic [WIDTH-1:0]   mult_mcand,
  output logic [WIDTH-1:0]   mult_mlier,
  output logic               mult_rst,
  input  logic [2*WIDTH-1:0] mult_product,
  output logic               busy
);

  if (LAT < mult_min_lat(WIDTH)) begin : g_lat_check
    $error("mult_issue_ctrl: LAT must be at least 3*WIDTH+1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("mult_issue_ctrl: DEPTH must be a power of two and at least 2");
  end

  localparam int RCW = $clog2(LAT);
  typedef logic [RCW-1:0] run_cnt_t;
  localparam run_cnt_t RUN_LAST = run_cnt_t'(LAT - 1);

  mult_issue_state_t state, state_nxt;
  run_cnt_t          run_cnt;
  logic              fifo_full;
  logic              accept;

  assign in_ready = (state == ST_IDLE) && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != ST_IDLE);
  // The multiplier is held in reset until the operands have been stable for a full LOAD cycle.
  assign mult_rst = (state == ST_IDLE) || (state == ST_LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: default assignment first keeps this block purely combinational (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (accept) state_nxt = ST_LOAD;
      ST_LOAD:    state_nxt = ST_RUN;
      ST_RUN:     if (run_cnt == RUN_LAST) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Counter stops at LAT-1 because RUN is left on that value; it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
    end else if (state == ST_LOAD) begin
      run_cnt <= '0;
    end else if (state == ST_RUN && run_cnt != RUN_LAST) begin
      run_cnt <= run_cnt + run_cnt_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mult_mcand <= '0;
      mult_mlier <= '0;
    end else if (accept) begin
      mult_mcand <= in_mcand;
      mult_mlier <= in_mlier;
    end
  end

  mult_result_fifo #(
    .DEPTH (DEPTH),
    .DW    (2 * WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (state == ST_CAPTURE),
    .push_data (mult_product),
    .pop       (out_ready),
    .full      (fifo_full),
    .valid     (out_valid),
    .head      (out_product)
  );

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Directed and randomized bench for mult_issue_ctrl with a behavioural multiplier attached.
module tb_mult_issue_ctrl;

  localparam int W         = 32;
  localparam int LAT       = 100;
  localparam int DEPTH     = 2;
  localparam int ACC2VALID = LAT + 2;
  localparam int MULT_WC   = 3 * W + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_mcand;
  logic [W-1:0]    in_mlier;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  out_product;
  logic [W-1:0]    mult_mcand;
  logic [W-1:0]    mult_mlier;
  logic            mult_rst;
  logic [2*W-1:0]  mult_product;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;

  mult_issue_ctrl #(.WIDTH(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_mcand     (in_mcand),
    .in_mlier     (in_mlier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_product  (out_product),
    .mult_mcand   (mult_mcand),
    .mult_mlier   (mult_mlier),
    .mult_rst     (mult_rst),
    .mult_product (mult_product),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: product is garbage until MULT_WC cycles out of reset.
  int m_cnt = 0;
  always @(posedge clk) begin
    if (mult_rst) begin
      m_cnt        <= 0;
      mult_product <= 64'hDEAD_BEEF_DEAD_BEEF;
    end else begin
      if (m_cnt < MULT_WC) m_cnt <= m_cnt + 1;
      if (m_cnt == MULT_WC - 1)
        mult_product <= {32'd0, mult_mcand} * {32'd0, mult_mlier};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the acceptance edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    int g = 0;
    in_mcand = a;
    in_mlier = b;
    in_valid = 1'b1;
    while (!in_ready && g < 1000) begin
      tick();
      g++;
    end
    if (!in_ready) check("issue_timeout", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int start, output int lat);
    lat = -1;
    for (int k = start + 1; k <= 300; k++) begin
      tick();
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_job(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [63:0] exp);
    int lat;
    issue(a, b);
    wait_valid(0, lat);
    check({tag, "_lat"}, 64'(lat), 64'(ACC2VALID));
    check({tag, "_prod"}, out_product, exp);
  endtask

  initial begin
    int          lat;
    int          bad;
    logic        ok;
    logic [W-1:0] a, b;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mcand  = '0;
    in_mlier  = '0;
    out_ready = 1'b0;
    #3;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_mult_rst",  64'(mult_rst),  64'd1);
    check("rst_mcand",     64'(mult_mcand), 64'd0);
    check("rst_mlier",     64'(mult_mlier), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Basic job with an always-ready consumer.
    out_ready = 1'b1;
    issue(32'd3, 32'd5);
    check("load_busy",     64'(busy),       64'd1);
    check("load_mult_rst", 64'(mult_rst),   64'd1);
    check("load_mcand",    64'(mult_mcand), 64'd3);
    check("load_mlier",    64'(mult_mlier), 64'd5);
    tick();
    check("run_mult_rst",  64'(mult_rst),   64'd0);
    check("run_in_ready",  64'(in_ready),   64'd0);
    wait_valid(1, lat);
    check("3x5_lat",       64'(lat),        64'(ACC2VALID));
    check("3x5_prod",      out_product,     64'h0000_0000_0000_000F);
    check("3x5_busy",      64'(busy),       64'd0);
    check("3x5_in_ready",  64'(in_ready),   64'd1);
    tick();
    check("3x5_popped",    64'(out_valid),  64'd0);

    run_job("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_job("zero", 32'd0, 32'h1234_5678, 64'd0);
    tick();

    // Back-pressure: two results fill the FIFO, the third job must wait for a pop.
    out_ready = 1'b0;
    run_job("bp1", 32'd2, 32'd3, 64'd6);
    issue(32'd4, 32'd5);
    repeat (ACC2VALID) tick();
    check("bp_full_in_ready", 64'(in_ready),  64'd0);
    check("bp_full_head",     out_product,    64'd6);
    check("bp_full_busy",     64'(busy),      64'd0);
    in_mcand = 32'd6;
    in_mlier = 32'd7;
    in_valid = 1'b1;
    ok = 1'b1;
    repeat (10) begin
      tick();
      if (in_ready !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    check("bp_stall", 64'(ok), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_head_after_pop", out_product,   64'd20);
    check("bp_in_ready_back",  64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("bp_third_busy",   64'(busy),       64'd1);
    check("bp_third_mcand",  64'(mult_mcand), 64'd6);
    repeat (ACC2VALID) tick();
    check("bp_third_done",   64'(busy),       64'd0);
    check("bp_drain0",       out_product,     64'd20);
    out_ready = 1'b1;
    tick();
    check("bp_drain1",       out_product,     64'd42);
    check("bp_drain1_valid", 64'(out_valid),  64'd1);
    tick();
    check("bp_drain_empty",  64'(out_valid),  64'd0);

    // Random operands, inputs toggled while the job is in flight.
    for (int j = 0; j < 4; j++) begin
      a = $urandom;
      b = $urandom;
      issue(a, b);
      bad = 0;
      lat = -1;
      for (int k = 1; k <= 300; k++) begin
        in_mcand = $urandom;
        in_mlier = $urandom;
        tick();
        if (mult_mcand !== a || mult_mlier !== b) bad++;
        if (out_valid) begin
          lat = k;
          break;
        end
      end
      check("rnd_operands_stable", 64'(bad), 64'd0);
      check("rnd_lat",  64'(lat), 64'(ACC2VALID));
      check("rnd_prod", out_product, {32'd0, a} * {32'd0, b});
      tick();
    end

    // Reset in the middle of RUN drops the job.
    issue(32'd11, 32'd13);
    repeat (41) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  64'(in_ready),   64'd1);
    check("mid_rst_out_valid", 64'(out_valid),  64'd0);
    check("mid_rst_busy",      64'(busy),       64'd0);
    check("mid_rst_mult_rst",  64'(mult_rst),   64'd1);
    check("mid_rst_mcand",     64'(mult_mcand), 64'd0);
    check("mid_rst_mlier",     64'(mult_mlier), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (150) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    check("mid_rst_no_result", 64'(ok), 64'd1);
    run_job("post_rst", 32'd7, 32'd9, 64'd63);
    tick();

    // Push and pop on the same edge keep one entry with the new product at the head.
    out_ready = 1'b0;
    run_job("pp_first", 32'd5, 32'd5, 64'd25);
    issue(32'd8, 32'd9);
    repeat (LAT + 1) tick();
    check("pp_capture_busy", 64'(busy),  64'd1);
    check("pp_old_head",     out_product, 64'd25);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pp_valid",    64'(out_valid), 64'd1);
    check("pp_new_head", out_product,    64'd72);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pp_one_entry", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
